// File: rtl/line_period_readout_if.sv
// Bundles the capture-side inputs, the bit-serial output stream and the status flags of line_period_readout.
// Latency: none. The interface only carries signals.
// Backpressure: sready from the consumer stalls the stream. The slave modport is the readout block and the master modport is its environment.
// Ports: start, period_in, pulse_in and sready run master->slave; sdata, svalid, slast, busy, done and timed_out run slave->master.
interface line_period_readout_if #(
    parameter int PIXELS       = 4,
    parameter int COUNTER_BITS = 15
);
    logic                           start;
    logic [PIXELS*COUNTER_BITS-1:0] period_in;
    logic [PIXELS-1:0]              pulse_in;
    logic                           sready;
    logic                           sdata;
    logic                           svalid;
    logic                           slast;
    logic                           busy;
    logic                           done;
    logic                           timed_out;

    modport master (
        output start, period_in, pulse_in, sready,
        input  sdata, svalid, slast, busy, done, timed_out
    );

    modport slave (
        input  start, period_in, pulse_in, sready,
        output sdata, svalid, slast, busy, done, timed_out
    );
endinterface

// File: rtl/line_period_readout.sv
// Captures one period per pixel column for each line. Capture ends when every column has reported or a timeout expires. The captured periods are then streamed out bit-serially, pixel 0 first and MSB first.
// Latency: the first bit is valid on the cycle after the capture mask completes. The stream carries PIXELS*COUNTER_BITS bits, and done pulses on the cycle after the last transfer.
// Backpressure: the stream advances only when svalid && sready. sdata holds while a bit is stalled.
// Ports: clk, rst (async, active high), and bus (line_period_readout_if.slave), which carries start, period_in, pulse_in, sready, sdata, svalid, slast, busy, done and timed_out.
module line_period_readout #(
    parameter int PIXELS         = 4,
    parameter int COUNTER_BITS   = 15,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    line_period_readout_if.slave    bus
);
    localparam int TOTAL = PIXELS * COUNTER_BITS;
    localparam int BCW   = $clog2(TOTAL + 1);
    localparam int TCW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(TOTAL - 1);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [PIXELS-1:0] mask, mask_nxt;
    logic [TOTAL-1:0]  shreg, shreg_nxt;
    logic [BCW-1:0]    bcnt, bcnt_nxt;
    logic [TCW-1:0]    tcnt, tcnt_nxt;
    logic              timed_out, timed_out_nxt;
    logic              done, done_nxt;
    logic [PIXELS-1:0] cap, mask_cap;
    logic              svalid, xfer;

    // The shadow registers double as the output shift register. Pixel p
    // lives at slice (PIXELS-1-p), so pixel 0's MSB sits at the top bit and
    // a plain left shift yields pixel 0 first, MSB first.
    assign svalid        = (state == SHIFT);
    assign xfer          = svalid && bus.sready;
    assign bus.svalid    = svalid;
    assign bus.sdata     = svalid & shreg[TOTAL-1];
    assign bus.slast     = svalid && (bcnt == LAST_BIT);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.timed_out = timed_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask      <= '0;
            shreg     <= '0;
            bcnt      <= '0;
            tcnt      <= '0;
            timed_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mask      <= mask_nxt;
            shreg     <= shreg_nxt;
            bcnt      <= bcnt_nxt;
            tcnt      <= tcnt_nxt;
            timed_out <= timed_out_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        mask_nxt      = mask;
        shreg_nxt     = shreg;
        bcnt_nxt      = bcnt;
        tcnt_nxt      = tcnt;
        timed_out_nxt = timed_out;
        done_nxt      = 1'b0;
        // Only the first pulse per pixel is captured. A pixel whose mask
        // bit is already set ignores later pulses.
        cap           = bus.pulse_in & ~mask;
        mask_cap      = mask | cap;

        case (state)
            IDLE: begin
                mask_nxt = '0;
                tcnt_nxt = '0;
                bcnt_nxt = '0;
                if (bus.start) begin
                    timed_out_nxt = 1'b0;
                    state_nxt     = ARM;
                end
            end

            ARM: begin
                for (int i = 0; i < PIXELS; i++) begin
                    if (cap[i]) begin
                        shreg_nxt[(PIXELS-1-i)*COUNTER_BITS +: COUNTER_BITS] =
                            bus.period_in[i*COUNTER_BITS +: COUNTER_BITS];
                    end
                end
                mask_nxt = mask_cap;
                // Completion is checked before the timeout, so a final pulse
                // that lands on the timeout cycle still counts as a full line.
                if (&mask_cap) begin
                    state_nxt = SHIFT;
                end else if (tcnt == TO_LAST) begin
                    for (int i = 0; i < PIXELS; i++) begin
                        if (!mask_cap[i]) begin
                            shreg_nxt[(PIXELS-1-i)*COUNTER_BITS +: COUNTER_BITS] = '1;
                        end
                    end
                    mask_nxt      = '1;
                    timed_out_nxt = 1'b1;
                    state_nxt     = SHIFT;
                end else begin
                    tcnt_nxt = tcnt + TCW'(1);
                end
            end

            SHIFT: begin
                if (xfer) begin
                    shreg_nxt = shreg << 1;
                    bcnt_nxt  = bcnt + BCW'(1);
                    if (bcnt == LAST_BIT) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_line_period_readout.sv
// Directed bench for line_period_readout configured with PIXELS=4, COUNTER_BITS=15 and TIMEOUT_CYCLES=100.
// Inputs are driven and outputs are sampled 1 ns after each rising edge, and expected streams are built from hand-chosen periods.
// Backpressure is exercised through random and long-low sready patterns.
module tb_line_period_readout;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    line_period_readout_if #(.PIXELS(4), .COUNTER_BITS(15)) bus ();

    line_period_readout #(
        .PIXELS(4), .COUNTER_BITS(15), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Layout of period_in: pixel 0 occupies the low slice.
    function automatic logic [59:0] pk(input logic [14:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Expected stream with bit k at position 59-k.
    function automatic logic [59:0] st(input logic [14:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
    endtask

    // Drive pixel i's pulse on ARM cycle w_i (-1 means never), and return the number of ARM cycles before svalid rose.
    task automatic arm_run(input logic [59:0] per, input int w0, w1, w2, w3, output int cyc);
        bus.period_in = per;
        cyc = 0;
        while (!bus.svalid && cyc < 400) begin
            bus.pulse_in = {cyc == w3, cyc == w2, cyc == w1, cyc == w0};
            step();
            cyc++;
        end
        bus.pulse_in = '0;
    endtask

    // Receive the stream. mode 0 holds sready high; mode 1 drives a random sready with 16-cycle low bursts.
    // When stop_at >= 0, return as soon as stop_at bits have transferred.
    task automatic recv(input int mode, input int stop_at, input logic [59:0] exp_s);
        int idx = 0;
        int cyc = 0;
        while (idx < 60 && idx != stop_at && cyc < 3000) begin
            if (mode == 0)                 bus.sready = 1'b1;
            else if ((cyc / 16) % 4 == 3)  bus.sready = 1'b0;
            else                           bus.sready = ($urandom_range(0, 2) != 0);
            if (bus.svalid) begin
                chk("sdata", bus.sdata, exp_s[59-idx]);
                if (bus.sready) begin
                    chk("slast", bus.slast, idx == 59);
                    idx++;
                end
            end
            step();
            cyc++;
        end
        bus.sready = 1'b0;
        if (stop_at < 0) begin
            chk("xfer_count", idx, 60);
            chk("done_pulse", bus.done, 1);
            chk("busy_after_line", bus.busy, 0);
            chk("svalid_after_line", bus.svalid, 0);
        end
    endtask

    logic [59:0] basic_per, basic_exp;
    int cyc;

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.period_in = '0;
        bus.pulse_in  = '0;
        bus.sready    = 1'b0;
        basic_per = pk(15'h0001, 15'h00FA, 15'h1234, 15'h7FFE);
        basic_exp = st(15'h0001, 15'h00FA, 15'h1234, 15'h7FFE);
        step(); step();
        chk("rst_outs_held", {bus.sdata, bus.svalid, bus.slast, bus.busy, bus.done, bus.timed_out}, 0);
        rst = 1'b0;
        step();
        chk("reset_svalid", bus.svalid, 0);
        chk("reset_sdata", bus.sdata, 0);
        chk("reset_slast", bus.slast, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_timed_out", bus.timed_out, 0);

        // Basic line.
        do_start();
        arm_run(basic_per, 0, 1, 2, 3, cyc);
        chk("basic_arm_cycles", cyc, 4);
        chk("basic_first_bit", bus.sdata, 0);
        recv(0, -1, basic_exp);
        chk("basic_timed_out", bus.timed_out, 0);
        step();
        chk("done_one_cycle", bus.done, 0);

        // Simultaneous pulses, then a duplicate pulse on pixel 2 after capture has closed.
        do_start();
        arm_run(pk(15'h0055, 15'h0055, 15'h0055, 15'h0055), 0, 0, 0, 0, cyc);
        chk("simul_arm_cycles", cyc, 1);
        bus.period_in = pk(15'h0055, 15'h0055, 15'h0AAA, 15'h0055);
        bus.pulse_in  = 4'b0100;
        step();
        bus.pulse_in  = '0;
        recv(0, -1, st(15'h0055, 15'h0055, 15'h0055, 15'h0055));

        // Backpressure.
        do_start();
        arm_run(basic_per, 0, 1, 2, 3, cyc);
        recv(1, -1, basic_exp);

        // Timeout with pixels 2 and 3 missing.
        do_start();
        arm_run(pk(15'h0010, 15'h0020, 15'h1111, 15'h2222), 3, 7, -1, -1, cyc);
        chk("timeout_arm_cycles", cyc, 100);
        chk("timeout_flag", bus.timed_out, 1);
        recv(0, -1, st(15'h0010, 15'h0020, 15'h7FFF, 15'h7FFF));
        chk("timeout_flag_sticky", bus.timed_out, 1);

        // Back-to-back: START in the DONE cycle; last pulse on the timeout cycle.
        do_start();
        chk("b2b_timed_out_cleared", bus.timed_out, 0);
        arm_run(pk(15'h0100, 15'h0200, 15'h0300, 15'h0400), 0, 1, 2, 99, cyc);
        chk("edge_arm_cycles", cyc, 100);
        chk("edge_timed_out", bus.timed_out, 0);
        recv(0, -1, st(15'h0100, 15'h0200, 15'h0300, 15'h0400));

        // Reset during ARM.
        do_start();
        bus.period_in = pk(15'h3333, 0, 0, 0);
        bus.pulse_in  = 4'b0001;
        step();
        bus.pulse_in  = '0;
        step();
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_arm_outs", {bus.sdata, bus.svalid, bus.slast, bus.busy, bus.done, bus.timed_out}, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_arm_done", bus.done, 0);
        do_start();
        arm_run(basic_per, 1, 0, 2, 3, cyc);
        chk("post_rst_arm_cycles", cyc, 4);
        recv(0, -1, basic_exp);

        // Reset during SHIFT at bit 20, with timed_out set.
        do_start();
        arm_run(pk(15'h0010, 15'h0020, 15'h1111, 15'h2222), 0, 1, -1, -1, cyc);
        recv(0, 20, st(15'h0010, 15'h0020, 15'h7FFF, 15'h7FFF));
        chk("pre_rst_svalid", bus.svalid, 1);
        chk("pre_rst_timed_out", bus.timed_out, 1);
        rst = 1'b1;
        #1;
        chk("rst_shift_outs", {bus.sdata, bus.svalid, bus.slast, bus.busy, bus.done, bus.timed_out}, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_shift_done", bus.done, 0);
        do_start();
        arm_run(basic_per, 0, 1, 2, 3, cyc);
        recv(1, -1, basic_exp);
        chk("post_rst_timed_out", bus.timed_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/line_period_readout.md
# line_period_readout

Readout end of the pixel frequency-measurement chain. Per image line it captures the measured period of each pixel column from the frequency counter bank, waiting until every column has produced a measurement or a timeout expires. It then streams the captured periods off-chip as a bit-serial stream with ready/valid backpressure. It is the reader counterpart of the line-load shift register feeding the frequency modules.

## Interface
- PIXELS, default 4: number of pixel columns per line (min 1).
- COUNTER_BITS, default 15: width of each period value.
- TIMEOUT_CYCLES, default 65535: ARM-state cycles before forcing line completion (min 1).
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  begin acquisition of a new line; honoured only in IDLE.
- PERIOD_IN  input  PIXELS*COUNTER_BITS  period from each frequency counter; pixel i at [i*COUNTER_BITS +: COUNTER_BITS].
- PULSE_IN  input  PIXELS  per-pixel measurement-complete strobe from the frequency counters.
- SREADY  input  1  downstream accepts the current bit.
- SDATA  output  1  serial data bit.
- SVALID  output  1  SDATA is valid.
- SLAST  output  1  asserted with the final bit of the line.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse at line completion.
- TIMED_OUT  output  1  sticky per line: at least one pixel was missing at timeout; cleared on accepted START.

## Operation
- States: IDLE, ARM, SHIFT.
- IDLE: START=1 -> ARM. Clears the capture-valid mask, the timeout counter, and TIMED_OUT.
- ARM: on each cycle, for every pixel i with PULSE_IN[i]=1 and mask[i]=0, latch PERIOD_IN slice i into shadow[i] and set mask[i]. First capture wins; later pulses for a captured pixel are ignored.
- ARM exit (complete): the mask including this cycle's captures is all ones -> SHIFT.
- ARM exit (timeout): the counter reaches TIMEOUT_CYCLES-1 with the mask incomplete. Every uncaptured pixel is loaded with all-ones (saturation marker), TIMED_OUT is set, and the state goes to SHIFT. If the last pulse arrives on the timeout cycle, it counts as complete; TIMED_OUT stays 0.
- SHIFT: output order is pixel 0 first, MSB first within each pixel. That gives PIXELS*COUNTER_BITS bits in total.
- Handshake: a bit is transferred when SVALID&&SREADY. SDATA must hold stable while SVALID=1 and SREADY=0.
- After the final transfer (SLAST=1): DONE pulses, and the state goes to IDLE.
- START outside IDLE is ignored.
- The bit counter needs at least clog2(PIXELS*COUNTER_BITS+1) bits. The timeout counter needs at least clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- Reset values: SDATA=0, SVALID=0, SLAST=0, BUSY=0, DONE=0, TIMED_OUT=0, state=IDLE. Shadow registers and mask are cleared.
- START sampled high at edge N: BUSY=1 from N+1, and PULSE_IN is captured from N+1.
- Mask completes at edge M: SVALID=1, and SDATA = MSB of pixel 0 from M+1.
- With SREADY held high, one bit transfers per cycle. SLAST is high on bit PIXELS*COUNTER_BITS-1.
- DONE=1 and BUSY=0 in the cycle after the last transfer. START is accepted in that same cycle.
- Timeout: with no pulses, SHIFT is entered TIMEOUT_CYCLES cycles after entering ARM.
- RST mid-line: outputs return to reset values immediately. Any partial line is discarded; no DONE is produced.

## Test plan
- Basic line: PIXELS=4, COUNTER_BITS=15. START, then pulses on pixels 0..3 on separate cycles with periods 0x0001, 0x00FA, 0x1234, 0x7FFE. Required: a 60-bit stream 000000000000001 ... 111111111111110, SLAST on bit 59, one DONE pulse, TIMED_OUT=0.
- Simultaneous, duplicate and late pulses: all 4 pulse on the same cycle with value 0x0055, then pixel 2 pulses again with 0x0AAA. Required: pixel 2 reads 0x0055, and SHIFT starts one cycle after the simultaneous pulse.
- Backpressure: SREADY toggled randomly, including long lows. Required: the stream is identical to the basic line, SDATA is stable while stalled, and the transfer count is exactly 60.
- Timeout: TIMEOUT_CYCLES=100, only pixels 0 and 1 pulse (0x0010, 0x0020). Required: pixels 2 and 3 read 0x7FFF, TIMED_OUT=1, and SHIFT is entered 100 cycles after ARM. Also check the last pulse landing on the timeout cycle: required TIMED_OUT=0.
- Reset mid-operation: assert RST during ARM and again during SHIFT bit 20. Required: all outputs are 0 the same cycle; after release, a new START gives a clean full line.
- Back-to-back lines: START asserted in the DONE cycle. Required: accepted, BUSY is high next cycle, and TIMED_OUT is cleared.
